// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: states, opcodes,
// ALU function codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_HALT     = 4'd12,
        S_FAULT    = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_LUI = 2'd2,
        CLS_BR  = 2'd3
    } alu_cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Only 16 codes fit in 4 bits, so signed/unsigned less-than branches
    // share the SLT/SLTU compare codes.
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;
    localparam logic [3:0] ALU_BR_EQ  = 4'd11;
    localparam logic [3:0] ALU_BR_NE  = 4'd12;
    localparam logic [3:0] ALU_BR_LT  = ALU_SLT;
    localparam logic [3:0] ALU_BR_GE  = 4'd13;
    localparam logic [3:0] ALU_BR_LTU = ALU_SLTU;
    localparam logic [3:0] ALU_BR_GEU = 4'd14;

    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_RS1  = 1'b1;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;
    localparam logic [1:0] WB_ALU_OUT = 2'd0;
    localparam logic [1:0] WB_MDR     = 2'd1;
    localparam logic [1:0] WB_PC      = 2'd2;
    localparam logic       IORD_PC    = 1'b0;
    localparam logic       IORD_ALU   = 1'b1;
    localparam logic       PC_SRC_ALU = 1'b0;
    localparam logic       PC_SRC_REG = 1'b1;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU function decode from instruction class, funct3 and funct7[5].
module mc_alu_dec
    import mc_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (cls)
            CLS_R, CLS_I: begin
                case (funct3)
                    3'b000: alu_op = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            CLS_LUI: alu_op = ALU_PASS_B;
            default: begin
                // funct3 010/011 are not branches; they fall back to EQ harmlessly
                case (funct3)
                    3'b001: alu_op = ALU_BR_NE;
                    3'b100: alu_op = ALU_BR_LT;
                    3'b101: alu_op = ALU_BR_GE;
                    3'b110: alu_op = ALU_BR_LTU;
                    3'b111: alu_op = ALU_BR_GEU;
                    default: alu_op = ALU_BR_EQ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// over a req/ack memory, counts retired instructions, flags halt and faults.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [CNT_W-1:0] retired_count,
    output logic             halted,
    output logic             fault,
    output logic [3:0]       state_out
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  retired_reg;
    logic              halted_reg, fault_reg;
    logic              timeout;
    logic              retire;
    alu_cls_t          alu_cls;
    logic [3:0]        dec_alu_op;

    assign timeout = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
            halted_reg   <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
            if (state_next == S_HALT)
                halted_reg <= 1'b1;
            if (state_next == S_FAULT)
                fault_reg <= 1'b1;
        end
    end

    // Memory-wait states share one timeout path; an ack always beats the timeout.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        case (state_reg)
            S_IDLE:     if (run) state_next = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ack) begin
                    case (state_reg)
                        S_FETCH:  state_next = S_DECODE;
                        S_MEM_RD: state_next = S_WB_MEM;
                        default:  state_next = S_FETCH;
                    endcase
                end else if (timeout) begin
                    state_next = S_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:              state_next = S_EXEC_R;
                    OP_I, OP_LUI:      state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_SYSTEM:         state_next = S_HALT;
                    default:           state_next = S_FAULT;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_MEM_ADDR: state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            S_FAULT:    state_next = S_FAULT;
            default:    state_next = S_FAULT;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        if (state_next == S_FETCH &&
            (state_reg == S_WB_ALU || state_reg == S_WB_MEM || state_reg == S_MEM_WR ||
             state_reg == S_BRANCH || state_reg == S_JAL))
            retire = 1'b1;
        if (state_reg == S_DECODE && state_next == S_HALT)
            retire = 1'b1;
    end

    always_comb begin
        alu_cls = CLS_R;
        case (state_reg)
            S_EXEC_I: alu_cls = (opcode == OP_LUI) ? CLS_LUI : CLS_I;
            S_BRANCH: alu_cls = CLS_BR;
            default:  alu_cls = CLS_R;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .cls      (alu_cls),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (dec_alu_op)
    );

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        iord      = IORD_PC;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_ALU;
        reg_write = 1'b0;
        wb_sel    = WB_ALU_OUT;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ack;
                pc_write  = mem_ack;
            end
            S_DECODE:   alu_src_b = SRC_B_IMM;
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = dec_alu_op;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = dec_alu_op;
            end
            S_WB_ALU:   reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = IORD_ALU;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = WB_MDR;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                iord    = IORD_ALU;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = dec_alu_op;
                pc_write  = branch_taken;
                pc_src    = PC_SRC_REG;
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_REG;
            end
            default: ;
        endcase
        // Strobes die in the reset cycle itself, even mid-handshake.
        if (rst) begin
            mem_req   = 1'b0;
            mem_wr    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign retired_count = retired_reg;
    assign halted        = halted_reg;
    assign fault         = fault_reg;
    assign state_out     = state_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (MEM_TIMEOUT=4): instruction sequences,
// wait states, timeout boundary, illegal opcode, halt and reset mid-access.
module tb_mc_control_fsm;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_EXEC_I = 4;
    localparam int ST_WB_ALU = 5, ST_MEM_ADDR = 6, ST_MEM_RD = 7, ST_WB_MEM = 8, ST_MEM_WR = 9;
    localparam int ST_BRANCH = 10, ST_JAL = 11, ST_HALT = 12, ST_FAULT = 13;

    logic        clk = 1'b0;
    logic        rst, run, funct7_5, branch_taken, mem_ack;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        mem_req, mem_wr, iord, ir_write, pc_write, pc_src, reg_write;
    logic        alu_src_a, halted, fault;
    logic [1:0]  wb_sel, alu_src_b;
    logic [3:0]  alu_op, state_out;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int start_cyc;

    mc_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .branch_taken(branch_taken), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .retired_count(retired_count), .halted(halted), .fault(fault),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
        ncyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; opcode = 7'd0; funct3 = 3'd0;
        funct7_5 = 1'b0; branch_taken = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (5) cyc();
        #1;
        chk("idle_state", state_out, ST_IDLE);
        chk("idle_strobes", {mem_req, ir_write, pc_write, reg_write}, 0);
        chk("idle_alu_op", alu_op, 0);
        chk("idle_retired", retired_count, 0);

        // ADD x3,x1,x2, zero-wait fetch
        run = 1'b1;
        cyc(); run = 1'b0; opcode = 7'b0110011; mem_ack = 1'b1; #1;
        chk("fetch_state", state_out, ST_FETCH);
        chk("fetch_req", {mem_req, iord, alu_src_b}, {1'b1, 1'b0, 2'd2});
        chk("fetch_ack_wr", {ir_write, pc_write, pc_src}, 3'b110);
        cyc(); mem_ack = 1'b0; #1;
        chk("add_decode", {state_out, alu_src_b}, {4'd2, 2'd1});
        cyc(); #1;
        chk("add_exec", {state_out, alu_src_a, alu_src_b, alu_op}, {4'd3, 1'b1, 2'd0, 4'd0});
        cyc(); #1;
        chk("add_wb", {state_out, reg_write, wb_sel}, {4'd5, 1'b1, 2'd0});
        chk("add_retired_pre", retired_count, 0);
        cyc(); #1;
        chk("add_retired", {state_out, retired_count}, {4'd1, 32'd1});

        // LW, two wait cycles at fetch and at data
        start_cyc = ncyc;
        #1 chk("lw_fwait_irw", {state_out, ir_write, iord}, {4'd1, 1'b0, 1'b0});
        cyc(); #1;
        chk("lw_fwait2", {state_out, ir_write}, {4'd1, 1'b0});
        cyc(); mem_ack = 1'b1; opcode = 7'b0000011; #1;
        chk("lw_fetch_ack", {state_out, ir_write}, {4'd1, 1'b1});
        cyc(); mem_ack = 1'b0; #1;
        chk("lw_decode", state_out, ST_DECODE);
        cyc(); #1;
        chk("lw_memaddr", {state_out, iord, alu_src_a, alu_src_b}, {4'd6, 1'b0, 1'b1, 2'd1});
        cyc(); #1;
        chk("lw_memrd_w1", {state_out, mem_req, iord, mem_wr}, {4'd7, 1'b1, 1'b1, 1'b0});
        cyc(); #1;
        chk("lw_memrd_w2", state_out, ST_MEM_RD);
        cyc(); mem_ack = 1'b1; #1;
        chk("lw_memrd_ack", {state_out, ir_write}, {4'd7, 1'b0});
        cyc(); mem_ack = 1'b0; #1;
        chk("lw_wbmem", {state_out, reg_write, wb_sel, iord}, {4'd8, 1'b1, 2'd1, 1'b0});
        cyc(); #1;
        chk("lw_cycles", ncyc - start_cyc, 9);
        chk("lw_retired", retired_count, 2);

        // BEQ taken
        start_cyc = ncyc;
        opcode = 7'b1100011; funct3 = 3'b000; mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0; cyc(); branch_taken = 1'b1; #1;
        chk("beq_branch", {state_out, alu_op, alu_src_a, alu_src_b}, {4'd10, 4'd11, 1'b1, 2'd0});
        chk("beq_taken_pc", {pc_write, pc_src}, 2'b11);
        cyc(); branch_taken = 1'b0; #1;
        chk("beq_cycles", ncyc - start_cyc, 3);
        chk("beq_retired", {state_out, retired_count}, {4'd1, 32'd3});

        // BNE not taken
        start_cyc = ncyc;
        funct3 = 3'b001; mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0; cyc(); #1;
        chk("bne_nt_pc", {state_out, alu_op, pc_write}, {4'd10, 4'd12, 1'b0});
        cyc(); #1;
        chk("bne_cycles", ncyc - start_cyc, 3);
        chk("bne_retired", retired_count, 4);

        // SRAI
        opcode = 7'b0010011; funct3 = 3'b101; funct7_5 = 1'b1; mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0; cyc(); #1;
        chk("srai_exec", {state_out, alu_op, alu_src_a, alu_src_b}, {4'd4, 4'd7, 1'b1, 2'd1});
        cyc(); cyc(); funct7_5 = 1'b0; #1;
        chk("srai_retired", {state_out, retired_count}, {4'd1, 32'd5});

        // JAL
        opcode = 7'b1101111; mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0; cyc(); #1;
        chk("jal_outputs", {state_out, reg_write, wb_sel, pc_write, pc_src},
            {4'd11, 1'b1, 2'd2, 1'b1, 1'b1});
        cyc(); #1;
        chk("jal_retired", {state_out, retired_count}, {4'd1, 32'd6});

        // SW with reset during the data wait
        opcode = 7'b0100011; mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0; cyc(); cyc(); cyc(); #1;
        chk("sw_memwr", {state_out, mem_req, mem_wr, iord}, {4'd9, 1'b1, 1'b1, 1'b1});
        rst = 1'b1; #1;
        chk("sw_rst_req_drop", mem_req, 0);
        cyc(); rst = 1'b0; #1;
        chk("sw_rst_state", {state_out, mem_req}, {4'd0, 1'b0});
        chk("sw_rst_counters", {retired_count, halted, fault}, {32'd0, 1'b0, 1'b0});

        // Timeout: no ack for 4 FETCH cycles
        run = 1'b1;
        cyc(); run = 1'b0; cyc(); cyc(); cyc(); #1;
        chk("to_fetch4", {state_out, fault}, {4'd1, 1'b0});
        cyc(); #1;
        chk("to_fault", {state_out, fault, mem_req}, {4'd13, 1'b1, 1'b0});
        run = 1'b1; cyc(); cyc(); run = 1'b0; #1;
        chk("to_fault_sticky", {state_out, fault}, {4'd13, 1'b1});

        // Ack on the 4th FETCH cycle wins over the timeout
        rst = 1'b1; cyc(); rst = 1'b0; run = 1'b1;
        cyc(); run = 1'b0; opcode = 7'b0000000; cyc(); cyc(); cyc(); mem_ack = 1'b1; #1;
        chk("late_ack_fetch", state_out, ST_FETCH);
        cyc(); mem_ack = 1'b0; #1;
        chk("late_ack_decode", {state_out, fault}, {4'd2, 1'b0});
        cyc(); #1;
        chk("illegal_fault", {state_out, fault, halted}, {4'd13, 1'b1, 1'b0});

        // ECALL halts and counts as retired
        rst = 1'b1; cyc(); rst = 1'b0; run = 1'b1;
        cyc(); run = 1'b0; opcode = 7'b1110011; mem_ack = 1'b1;
        cyc(); mem_ack = 1'b0; cyc(); #1;
        chk("ecall_halt", {state_out, halted, fault}, {4'd12, 1'b1, 1'b0});
        chk("ecall_retired", retired_count, 1);
        run = 1'b1; cyc(); run = 1'b0; #1;
        chk("halt_sticky", {state_out, halted, mem_req}, {4'd12, 1'b1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
